// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: PC source encodings and the canonical bubble instruction.
package riscv_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_IMM = 2'b01,
        PC_ALU = 2'b10
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/if_stage_if_idreg.sv
// IF/ID pipeline register: flush to a bubble, hold on stall, or load a fetched instruction.
module IF_IDReg #(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o
);

    // Flush leaves pc_o/pcPlus4_o alone; only the instruction slot becomes a bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            instr_o   <= NOP_INSTR;
            pc_o      <= '0;
            pcPlus4_o <= '0;
        end else if (flush_i) begin
            valid_o   <= 1'b0;
            instr_o   <= NOP_INSTR;
        end else if (hold_i) begin
            valid_o   <= valid_o;
        end else if (load_i) begin
            valid_o   <= 1'b1;
            instr_o   <= instr_i;
            pc_o      <= pc_i;
            pcPlus4_o <= pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, redirect/flush handling, stall buffering.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic [1:0]  PCsrc_i,
    input  logic [31:0] pcPlusImm_i,
    input  logic [31:0] ALUout_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pcPlus4_o
);

    import riscv_pkg::PC_IMM;
    import riscv_pkg::PC_ALU;

    typedef enum logic [1:0] {REQ, WAIT, HOLD, DISCARD} state_e;

    state_e      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic        redirect;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic        ifid_flush;

    always_comb begin
        redirect = 1'b0;
        target   = pc;
        case (PCsrc_i)
            PC_IMM: begin
                redirect = 1'b1;
                target   = pcPlusImm_i;
            end
            PC_ALU: begin
                redirect = 1'b1;
                target   = ALUout_i & ~32'd1;
            end
            default: ;
        endcase
    end

    assign deliver       = !redirect && !stall_i &&
                           ((state == WAIT && imem_rvalid_i) || state == HOLD);
    assign deliver_instr = (state == HOLD) ? hold_buf : imem_rdata_i;
    assign ifid_flush    = redirect || (!stall_i && !deliver);

    // Request is a decode of REQ, gated by reset so nothing is issued while held in reset.
    assign imem_req_o  = rst_ni && (state == REQ);
    assign imem_addr_o = pc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= REQ;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= DISCARD;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= imem_rvalid_i ? REQ : DISCARD;
                    end else if (imem_rvalid_i) begin
                        if (stall_i) begin
                            hold_buf <= imem_rdata_i;
                            state    <= HOLD;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= REQ;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (!stall_i) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    // A redirect coinciding with the stale response still consumes it,
                    // otherwise DISCARD would wait for a response that never comes.
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_rvalid_i) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    IF_IDReg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .load_i   (deliver),
        .flush_i  (ifid_flush),
        .hold_i   (stall_i),
        .instr_i  (deliver_instr),
        .pc_i     (pc),
        .valid_o  (valid_o),
        .instr_o  (instr_o),
        .pc_o     (pc_o),
        .pcPlus4_o(pcPlus4_o)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle-by-cycle memory responses with hand-computed expectations.
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic [1:0]  PCsrc_i;
    logic [31:0] pcPlusImm_i;
    logic [31:0] ALUout_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        imem_req_o,  req2;
    logic [31:0] imem_addr_o, addr2;
    logic        valid_o,     valid2;
    logic [31:0] instr_o,     instr2;
    logic [31:0] pc_o,        pc2;
    logic [31:0] pcPlus4_o,   pcp42;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    if_stage #(
        .RESET_PC (32'hBFC0_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .PCsrc_i(PCsrc_i),
        .pcPlusImm_i(pcPlusImm_i), .ALUout_i(ALUout_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid_o), .instr_o(instr_o), .pc_o(pc_o), .pcPlus4_o(pcPlus4_o)
    );

    if_stage #(
        .RESET_PC (32'hFFFF_FFFC),
        .NOP_INSTR(32'h0000_0013)
    ) dut_wrap (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .PCsrc_i(PCsrc_i),
        .pcPlusImm_i(pcPlusImm_i), .ALUout_i(ALUout_i),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .valid_o(valid2), .instr_o(instr2), .pc_o(pc2), .pcPlus4_o(pcp42)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; stall_i = 1'b0; PCsrc_i = 2'b00; pcPlusImm_i = '0; ALUout_i = '0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        tick(); tick();
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req_o); end
        n_checks++; if (imem_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL reset_addr: got %h want bfc00000", imem_addr_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
        n_checks++; if (instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", instr_o); end
        n_checks++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", pc_o); end
        n_checks++; if (pcPlus4_o !== 32'h0) begin n_fail++; $display("FAIL reset_pcp4: got %h want 00000000", pcPlus4_o); end
        rst_ni = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL first_req: got %0b want 1", imem_req_o); end
        n_checks++; if (imem_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL first_addr: got %h want bfc00000", imem_addr_o); end
    endtask

    task automatic test_first_fetch();
        tick();
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL wait_req: got %0b want 0", imem_req_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0050_0093;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL ff_valid: got %0b want 1", valid_o); end
        n_checks++; if (instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL ff_instr: got %h want 00500093", instr_o); end
        n_checks++; if (pc_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL ff_pc: got %h want bfc00000", pc_o); end
        n_checks++; if (pcPlus4_o !== 32'hBFC0_0004) begin n_fail++; $display("FAIL ff_pcp4: got %h want bfc00004", pcPlus4_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0004) begin n_fail++; $display("FAIL ff_next_req: got %0b/%h want 1/bfc00004", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_stall();
        stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hA1A1_A1A1;
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req1: got %0b want 0", imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h0050_0093) begin n_fail++; $display("FAIL stall_hold1: got %0b/%h want 1/00500093", valid_o, instr_o); end
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req2: got %0b want 0", imem_req_o); end
        tick();
        stall_i = 1'b0;
        n_checks++; if (instr_o !== 32'h0050_0093 || pc_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL stall_hold2: got %h/%h want 00500093/bfc00000", instr_o, pc_o); end
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_req3: got %0b want 0", imem_req_o); end
        tick();
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'hA1A1_A1A1) begin n_fail++; $display("FAIL stall_release_instr: got %0b/%h want 1/a1a1a1a1", valid_o, instr_o); end
        n_checks++; if (pc_o !== 32'hBFC0_0004 || pcPlus4_o !== 32'hBFC0_0008) begin n_fail++; $display("FAIL stall_release_pc: got %h/%h want bfc00004/bfc00008", pc_o, pcPlus4_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0008) begin n_fail++; $display("FAIL stall_next_req: got %0b/%h want 1/bfc00008", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_bubble();
        tick();
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL bubble_instr: got %0b/%h want 0/00000013", valid_o, instr_o); end
        n_checks++; if (pc_o !== 32'hBFC0_0004 || pcPlus4_o !== 32'hBFC0_0008) begin n_fail++; $display("FAIL bubble_pc: got %h/%h want bfc00004/bfc00008", pc_o, pcPlus4_o); end
    endtask

    task automatic test_redirect_imm();
        PCsrc_i = 2'b01; pcPlusImm_i = 32'h0000_0100;
        tick();
        PCsrc_i = 2'b00;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        n_checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL imm_discard: got %0b/%0b want 0/0", valid_o, imem_req_o); end
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL imm_dropped: got %0b/%h want 0/00000013", valid_o, instr_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100) begin n_fail++; $display("FAIL imm_target: got %0b/%h want 1/00000100", imem_req_o, imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1111_1111;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h1111_1111 || pc_o !== 32'h100 || pcPlus4_o !== 32'h104) begin n_fail++; $display("FAIL imm_fetch: got %0b/%h/%h/%h want 1/11111111/00000100/00000104", valid_o, instr_o, pc_o, pcPlus4_o); end
    endtask

    task automatic test_redirect_alu_hold();
        stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222;
        tick();
        imem_rvalid_i = 1'b0;
        PCsrc_i = 2'b10; ALUout_i = 32'h0000_0203;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h1111_1111) begin n_fail++; $display("FAIL alu_pre_hold: got %0b/%h want 1/11111111", valid_o, instr_o); end
        tick();
        PCsrc_i = 2'b00; stall_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL alu_flush: got %0b/%h want 0/00000013", valid_o, instr_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0202) begin n_fail++; $display("FAIL alu_target: got %0b/%h want 1/00000202", imem_req_o, imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h3333_3333;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (instr_o !== 32'h3333_3333 || pc_o !== 32'h202 || pcPlus4_o !== 32'h206) begin n_fail++; $display("FAIL alu_fetch: got %h/%h/%h want 33333333/00000202/00000206", instr_o, pc_o, pcPlus4_o); end
    endtask

    task automatic test_double_redirect();
        PCsrc_i = 2'b01; pcPlusImm_i = 32'h0000_0300;
        tick();
        PCsrc_i = 2'b10; ALUout_i = 32'h0000_0401;
        tick();
        PCsrc_i = 2'b00;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h4444_4444;
        n_checks++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL dbl_discard: got %0b/%0b want 0/0", imem_req_o, valid_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h5555_5555;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0400) begin n_fail++; $display("FAIL dbl_target: got %0b/%h want 1/00000400", imem_req_o, imem_addr_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL dbl_dropped: got %0b want 0", valid_o); end
        tick();
        imem_rdata_i = 32'h6666_6666;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid_o !== 1'b1 || instr_o !== 32'h6666_6666 || pc_o !== 32'h400) begin n_fail++; $display("FAIL req_ignores_rvalid: got %0b/%h/%h want 1/66666666/00000400", valid_o, instr_o, pc_o); end
    endtask

    task automatic test_reset_midfetch();
        tick();
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_req_valid: got %0b/%0b want 0/0", imem_req_o, valid_o); end
        n_checks++; if (instr_o !== 32'h0000_0013 || pc_o !== 32'h0 || pcPlus4_o !== 32'h0) begin n_fail++; $display("FAIL arst_ifid: got %h/%h/%h want 00000013/00000000/00000000", instr_o, pc_o, pcPlus4_o); end
        n_checks++; if (imem_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL arst_pc: got %h want bfc00000", imem_addr_o); end
        tick();
        rst_ni = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL arst_fresh_req: got %0b/%h want 1/bfc00000", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_wrap();
        n_checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first_req: got %0b/%h want 1/fffffffc", req2, addr2); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h7777_7777;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFFC || pcp42 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcp4: got %0b/%h/%h want 1/fffffffc/00000000", valid2, pc2, pcp42); end
        n_checks++; if (req2 !== 1'b1 || addr2 !== 32'h0) begin n_fail++; $display("FAIL wrap_second_addr: got %0b/%h want 1/00000000", req2, addr2); end
        n_checks++; if (instr_o !== 32'h7777_7777 || pc_o !== 32'hBFC0_0000) begin n_fail++; $display("FAIL post_reset_fetch: got %h/%h want 77777777/bfc00000", instr_o, pc_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h8888_8888;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (instr2 !== 32'h8888_8888 || pc2 !== 32'h0 || pcp42 !== 32'h4 || addr2 !== 32'h4) begin n_fail++; $display("FAIL wrap_second_fetch: got %h/%h/%h/%h want 88888888/00000000/00000004/00000004", instr2, pc2, pcp42, addr2); end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_bubble();
        test_redirect_imm();
        test_redirect_alu_hold();
        test_double_redirect();
        test_reset_midfetch();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
